// File: rtl/conv_result_capture.sv
// Capture side of the convolution result stream: frame checking, result buffer and read port.
// Defining CONV_CHECKSUM_EN adds a running 16-bit sum of the accepted elements.
module conv_result_capture #(
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned OUT_M     = 8,
  parameter int unsigned OUT_N     = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic [ACC_WIDTH-1:0]                 in_elem,
  input  logic                                 in_row_end,
  input  logic                                 in_last,
  input  logic [3:0]                           in_row_idx,
  input  logic [3:0]                           in_col_idx,
  input  logic                                 rd_en,
  input  logic [3:0]                           rd_row,
  input  logic [3:0]                           rd_col,
  output logic [ACC_WIDTH-1:0]                 rd_data,
  output logic                                 rd_valid,
  output logic                                 capturing,
  output logic                                 frame_done,
  output logic                                 frame_err,
  output logic [$clog2(OUT_M*OUT_N+1)-1:0]     elem_count,
  output logic [ACC_WIDTH-1:0]                 max_elem,
  output logic [3:0]                           max_row,
  output logic [3:0]                           max_col,
  output logic [15:0]                          checksum
);

  localparam int unsigned Depth = OUT_M * OUT_N;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  typedef enum logic [1:0] {StIdle, StCapt, StDone, StErr} state_e;

  state_e               state_q, state_d;
  logic [3:0]           exp_row_q, exp_row_d;
  logic [3:0]           exp_col_q, exp_col_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [ACC_WIDTH-1:0] max_q, max_d;
  logic [3:0]           max_row_q, max_row_d;
  logic [3:0]           max_col_q, max_col_d;

  logic [ACC_WIDTH-1:0] mem [Depth];
  logic                 last_col, last_row, beat_legal, wr_en, rd_in_range;
  logic [AddrW-1:0]     wr_addr, rd_addr;

  assign last_col   = (exp_col_q == 4'(OUT_N - 1));
  assign last_row   = (exp_row_q == 4'(OUT_M - 1));
  assign beat_legal = (in_row_idx == exp_row_q) && (in_col_idx == exp_col_q) &&
                      (in_row_end == last_col) && (in_last == (last_row && last_col));
  assign wr_addr    = AddrW'(exp_row_q) * AddrW'(OUT_N) + AddrW'(exp_col_q);
  assign rd_addr    = AddrW'(rd_row) * AddrW'(OUT_N) + AddrW'(rd_col);
  assign rd_in_range = (rd_row < 4'(OUT_M)) && (rd_col < 4'(OUT_N));

  always_comb begin
    state_d   = state_q;
    exp_row_d = exp_row_q;
    exp_col_d = exp_col_q;
    count_d   = count_q;
    max_d     = max_q;
    max_row_d = max_row_q;
    max_col_d = max_col_q;
    wr_en     = 1'b0;
    if (clear) begin
      // clear beats any coincident element, which is simply dropped
      state_d   = StCapt;
      exp_row_d = '0;
      exp_col_d = '0;
      count_d   = '0;
      max_d     = '0;
      max_row_d = '0;
      max_col_d = '0;
    end else if (in_valid) begin
      case (state_q)
        StCapt: begin
          if (beat_legal) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            if (last_col) begin
              exp_col_d = '0;
              exp_row_d = exp_row_q + 4'd1;
            end else begin
              exp_col_d = exp_col_q + 4'd1;
            end
            if ((in_elem > max_q) || (count_q == '0)) begin
              max_d     = in_elem;
              max_row_d = exp_row_q;
              max_col_d = exp_col_q;
            end
            if (in_last) state_d = StDone;
          end else begin
            state_d = StErr;
          end
        end
        StDone:  state_d = StErr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      exp_row_q <= '0;
      exp_col_q <= '0;
      count_q   <= '0;
      max_q     <= '0;
      max_row_q <= '0;
      max_col_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_row_q <= exp_row_d;
      exp_col_q <= exp_col_d;
      count_q   <= count_d;
      max_q     <= max_d;
      max_row_q <= max_row_d;
      max_col_q <= max_col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_elem;
  end

  // Read samples the array before the same-edge write lands, so it returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

`ifdef CONV_CHECKSUM_EN
  logic [15:0] sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (wr_en) begin
      sum_q <= sum_q + 16'(in_elem);
    end
  end
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign capturing  = (state_q == StCapt);
  assign frame_done = (state_q == StDone);
  assign frame_err  = (state_q == StErr);
  assign elem_count = count_q;
  assign max_elem   = max_q;
  assign max_row    = max_row_q;
  assign max_col    = max_col_q;

endmodule

// File: tb/tb_conv_result_capture.sv
// Self-checking bench for conv_result_capture: frame-level model compared every cycle,
// plus literal expectations from hand-worked frames.
module tb_conv_result_capture;

  localparam int AccW = 12;
`ifdef CONV_CHECKSUM_EN
  localparam int ExpSum1 = 3160;
  localparam int ExpSum5 = 11160;
`else
  localparam int ExpSum1 = 0;
  localparam int ExpSum5 = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, clear, in_valid, in_row_end, in_last, rd_en;
  logic [AccW-1:0] in_elem;
  logic [3:0]      in_row_idx, in_col_idx, rd_row, rd_col;
  logic [AccW-1:0] rd_data, max_elem;
  logic            rd_valid, capturing, frame_done, frame_err;
  logic [6:0]      elem_count;
  logic [3:0]      max_row, max_col;
  logic [15:0]     checksum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_result_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_elem    (in_elem),
    .in_row_end (in_row_end),
    .in_last    (in_last),
    .in_row_idx (in_row_idx),
    .in_col_idx (in_col_idx),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .capturing  (capturing),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .elem_count (elem_count),
    .max_elem   (max_elem),
    .max_row    (max_row),
    .max_col    (max_col),
    .checksum   (checksum)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: k is the position of the next expected element in raster order.
  int  m_mode;  // 0 idle, 1 capturing, 2 done, 3 error
  int  m_k, m_max, m_maxr, m_maxc, m_sum, m_rd_data;
  bit  m_rd_valid, m_rd_known, m_seen_reset;
  int  m_buf [80];
  bit  m_known [80];

  initial for (int i = 0; i < 80; i++) m_known[i] = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_k <= 0; m_max <= 0; m_maxr <= 0; m_maxc <= 0; m_sum <= 0;
      m_rd_valid <= 1'b0; m_rd_data <= 0; m_rd_known <= 1'b1; m_seen_reset <= 1'b1;
    end else begin
      int r, c, a;
      bit legal;
      m_rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_row >= 8 || rd_col >= 10) begin
          m_rd_data <= 0; m_rd_known <= 1'b1;
        end else begin
          a = int'(rd_row) * 10 + int'(rd_col);
          m_rd_data <= m_buf[a]; m_rd_known <= m_known[a];
        end
      end
      if (clear) begin
        m_mode <= 1; m_k <= 0; m_max <= 0; m_maxr <= 0; m_maxc <= 0; m_sum <= 0;
      end else if (in_valid && m_mode == 1) begin
        r = m_k / 10;
        c = m_k % 10;
        legal = (int'(in_row_idx) == r) && (int'(in_col_idx) == c) &&
                (in_row_end == (c == 9)) && (in_last == (m_k == 79));
        if (legal) begin
          m_buf[m_k] <= int'(in_elem);
          m_known[m_k] <= 1'b1;
          m_k <= m_k + 1;
          m_sum <= (m_sum + int'(in_elem)) % 65536;
          if (m_k == 0 || int'(in_elem) > m_max) begin
            m_max <= int'(in_elem); m_maxr <= r; m_maxc <= c;
          end
          if (in_last) m_mode <= 2;
        end else begin
          m_mode <= 3;
        end
      end else if (in_valid && m_mode == 2) begin
        m_mode <= 3;
      end
    end
  end

  always @(negedge clk) begin
    if (m_seen_reset) begin
      chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
      if (m_rd_known) chk("rd_data", int'(rd_data), m_rd_data);
      chk("capturing", int'(capturing), int'(m_mode == 1));
      chk("frame_done", int'(frame_done), int'(m_mode == 2));
      chk("frame_err", int'(frame_err), int'(m_mode == 3));
      chk("elem_count", int'(elem_count), m_k);
      chk("max_elem", int'(max_elem), m_max);
      chk("max_row", int'(max_row), m_maxr);
      chk("max_col", int'(max_col), m_maxc);
`ifdef CONV_CHECKSUM_EN
      chk("checksum", int'(checksum), m_sum);
`else
      chk("checksum", int'(checksum), 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send(input int r, input int c, input int e, input bit re, input bit l);
    in_valid   = 1'b1;
    in_row_idx = 4'(r);
    in_col_idx = 4'(c);
    in_elem    = AccW'(e);
    in_row_end = re;
    in_last    = l;
    tick();
    in_valid   = 1'b0;
    in_row_end = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic rd(input int r, input int c);
    rd_en  = 1'b1;
    rd_row = 4'(r);
    rd_col = 4'(c);
    tick();
    rd_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_row_end = 1'b0; in_last = 1'b0;
    in_elem = '0; in_row_idx = '0; in_col_idx = '0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset capturing", int'(capturing), 0);
    chk("reset elem_count", int'(elem_count), 0);
    chk("reset rd_data", int'(rd_data), 0);

    // 1: full frame, one beat per cycle
    do_clear();
    for (int k = 0; k < 80; k++) send(k / 10, k % 10, k, (k % 10) == 9, k == 79);
    chk("t1 frame_done", int'(frame_done), 1);
    chk("t1 frame_err", int'(frame_err), 0);
    chk("t1 elem_count", int'(elem_count), 80);
    chk("t1 max_elem", int'(max_elem), 79);
    chk("t1 max_row", int'(max_row), 7);
    chk("t1 max_col", int'(max_col), 9);
    chk("t1 checksum", int'(checksum), ExpSum1);

    // 2: reads, including out of range and data hold
    rd(3, 4);
    chk("t2 rd_valid", int'(rd_valid), 1);
    chk("t2 rd_data", int'(rd_data), 34);
    rd(8, 0);
    chk("t2 oor rd_valid", int'(rd_valid), 1);
    chk("t2 oor rd_data", int'(rd_data), 0);
    rd(6, 2);
    tick();
    chk("t2 rd_valid drop", int'(rd_valid), 0);
    chk("t2 rd_data hold", int'(rd_data), 62);

    // 3: column skip
    do_clear();
    send(0, 0, 7, 1'b0, 1'b0);
    send(0, 1, 8, 1'b0, 1'b0);
    send(0, 3, 9, 1'b0, 1'b0);
    chk("t3 frame_err", int'(frame_err), 1);
    chk("t3 elem_count", int'(elem_count), 2);
    chk("t3 capturing", int'(capturing), 0);
    send(0, 2, 9, 1'b0, 1'b0);
    chk("t3 err sticky", int'(frame_err), 1);

    // 4: equal elements then missing row_end
    do_clear();
    for (int c = 0; c < 9; c++) send(0, c, 5, 1'b0, 1'b0);
    send(0, 9, 5, 1'b0, 1'b0);
    chk("t4 frame_err", int'(frame_err), 1);
    chk("t4 elem_count", int'(elem_count), 9);
    chk("t4 max_elem", int'(max_elem), 5);
    chk("t4 max_row", int'(max_row), 0);
    chk("t4 max_col", int'(max_col), 0);

    // 5: frame with gaps, read-during-write, then overrun
    do_clear();
    for (int k = 0; k < 80; k++) begin
      if (k == 23) begin
        rd_en = 1'b1; rd_row = 4'd2; rd_col = 4'd3;
      end
      send(k / 10, k % 10, 100 + k, (k % 10) == 9, k == 79);
      if (k == 23) begin
        rd_en = 1'b0;
        chk("t5 rd old data", int'(rd_data), 23);
      end
      if (k % 7 == 3) tick();
    end
    chk("t5 frame_done", int'(frame_done), 1);
    chk("t5 checksum", int'(checksum), ExpSum5);
    send(0, 0, 999, 1'b0, 1'b0);
    chk("t5 overrun done", int'(frame_done), 0);
    chk("t5 overrun err", int'(frame_err), 1);
    rd(0, 0);
    chk("t5 buf (0,0)", int'(rd_data), 100);
    rd(7, 9);
    chk("t5 buf (7,9)", int'(rd_data), 179);

    // 6: reset mid-frame, then idle beat ignored, clear coincident with a beat
    do_clear();
    for (int c = 0; c < 4; c++) send(0, c, 50 + c, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6 rst capturing", int'(capturing), 0);
    chk("t6 rst elem_count", int'(elem_count), 0);
    chk("t6 rst max_elem", int'(max_elem), 0);
    chk("t6 rst rd_data", int'(rd_data), 0);
    tick();
    rst_n = 1'b1;
    send(0, 0, 3, 1'b0, 1'b0);
    chk("t6 idle ignore", int'(elem_count), 0);
    chk("t6 idle state", int'(capturing), 0);
    clear = 1'b1;
    send(0, 0, 3, 1'b0, 1'b0);
    clear = 1'b0;
    chk("t6 clear wins capt", int'(capturing), 1);
    chk("t6 clear wins count", int'(elem_count), 0);
    send(0, 0, 3, 1'b0, 1'b0);
    chk("t6 first beat", int'(elem_count), 1);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
